// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared constants for the multi-channel clock divider.
//   CH_IDX_W           : width of the config channel index
//   DIV_2HZ/400HZ/25MHZ: divisors for the standard 100 MHz top-level rates
//   half_period_to_div : converts a half-period in clk cycles to a divisor
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CH_IDX_W = 4;

    // Divisor D yields a half-period of D+1 clk cycles.
    localparam int unsigned DIV_2HZ   = 24999999;
    localparam int unsigned DIV_400HZ = 124999;
    localparam int unsigned DIV_25MHZ = 1;

    // A half-period of zero cycles is meaningless; clamp it to the fastest rate.
    function automatic int unsigned half_period_to_div(input int unsigned half_cycles);
        return (half_cycles == 0) ? 0 : half_cycles - 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// ---------------------------------------------------------------------------
// clk_div_channel
// One divider channel: counter, active divisor, shadow divisor with pending
// flag, registered square wave and one-cycle toggle tick.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   en           : run enable (0 holds the channel idle at phase zero)
//   restart      : phase-align pulse, overrides a coincident wrap
//   wr, wr_div   : accepted divisor write into the shadow register
//   pending      : shadow holds a divisor not yet applied
//   div_clk      : divided square wave
//   div_tick     : one-cycle pulse on each div_clk toggle
// ---------------------------------------------------------------------------
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               CNT_W  = 25,
    parameter logic [CNT_W-1:0] INIT_D = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
    output logic             div_clk,
    output logic             div_tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            div_q    <= INIT_D;
            shadow   <= INIT_D;
            pending  <= 1'b0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            if (restart || !en) begin
                // Idle or realigned: park at phase zero and take any
                // waiting divisor right away, since no half-period is running.
                cnt      <= '0;
                div_clk  <= 1'b0;
                div_tick <= 1'b0;
                if (pending) begin
                    div_q   <= shadow;
                    pending <= 1'b0;
                end
            end else if (cnt == div_q) begin
                // Wrap: the swap happens here so the new divisor governs
                // the whole next half-period, never a partial one.
                cnt      <= '0;
                div_clk  <= ~div_clk;
                div_tick <= 1'b1;
                if (pending) begin
                    div_q   <= shadow;
                    pending <= 1'b0;
                end
            end else begin
                cnt      <= cnt + 1'b1;
                div_tick <= 1'b0;
            end
            // Accepts only arrive while pending is clear, so a write landing
            // on a wrap or restart edge stays pending for the next wrap.
            if (wr) begin
                shadow  <= wr_div;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// Runtime-programmable multi-channel clock divider. Each channel emits a
// square wave and a one-cycle tick per toggle; ticks are the intended
// clock enables for downstream logic.
// Ports:
//   clk, rst      : system clock, asynchronous active-low reset
//   ch_en         : per-channel run enable
//   sync_restart  : one-cycle pulse that phase-aligns all channels
//   cfg_valid     : divisor write request
//   cfg_ch        : target channel index
//   cfg_div       : new divisor (half-period = cfg_div+1 cycles)
//   cfg_ready     : write accepted when cfg_valid && cfg_ready
//   cfg_err       : one-cycle pulse after a write to a missing channel
//   div_clk       : divided square waves
//   div_tick      : one-cycle pulse on each div_clk toggle
//
// Config handshake: a write transfers on any clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends combinationally on cfg_ch: it is
// low only while the addressed channel already holds an unapplied divisor, so
// a requester keeps cfg_valid/cfg_ch/cfg_div stable until it sees ready.
// Out-of-range indices are always ready; the write is dropped and flagged.
// ---------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      CNT_W    = 25,
    parameter logic [NUM_CH*CNT_W-1:0] INIT_DIV = {25'(DIV_25MHZ), 25'(DIV_400HZ), 25'(DIV_2HZ)},
    parameter logic [NUM_CH-1:0]       EN_INIT  = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_restart,
    input  logic                cfg_valid,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   div_clk,
    output logic [NUM_CH-1:0]   div_tick
);

    localparam int              IDX_SPAN = 1 << CH_IDX_W;
    localparam logic [CH_IDX_W:0] NUM_CH_L = (CH_IDX_W+1)'(NUM_CH);

    // EN_INIT documents the tie-off for ch_en; it must match the channel count.
    if (NUM_CH < 1 || NUM_CH > IDX_SPAN || $bits(EN_INIT) != NUM_CH) begin : g_bad_params
        $error("clk_div_multi: NUM_CH must be 1..16 and EN_INIT NUM_CH bits wide");
    end

    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   wr;
    logic [IDX_SPAN-1:0] pend_pad;
    logic                cfg_oor;

    // Pad pending out to the full index range so any cfg_ch can select it.
    always_comb begin
        pend_pad               = '0;
        pend_pad[NUM_CH-1:0]   = pending;
    end

    assign cfg_oor   = ({1'b0, cfg_ch} >= NUM_CH_L);
    assign cfg_ready = cfg_oor | ~pend_pad[cfg_ch];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && cfg_oor;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && !cfg_oor && (cfg_ch == CH_IDX_W'(i));

        clk_div_channel #(
            .CNT_W  (CNT_W),
            .INIT_D (INIT_DIV[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (ch_en[i]),
            .restart  (sync_restart),
            .wr       (wr[i]),
            .wr_div   (cfg_div),
            .pending  (pending[i]),
            .div_clk  (div_clk[i]),
            .div_tick (div_tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
// Directed bench for clk_div_multi with NUM_CH=3, CNT_W=8, divisors 3/2/1.
// Stimulus pushes the expected {div_clk, div_tick, cfg_err} for each upcoming
// clock edge onto exp_q, stamped with the edge number. The expected values
// come from the closed-form divider schedule: k edges after a phase origin,
// a tick is due when k is a multiple of D+1 and div_clk has toggled k/(D+1)
// times. Divisor changes move the origin to the hand-computed wrap edge.
// Point checks (cfg_ready, asynchronous reset) are queued on dq_*; the
// monitor alone compares and counts.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int NC = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] ch_en = 3'b111;
    logic          sync_restart = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [3:0]    cfg_ch = 4'd0;
    logic [CW-1:0] cfg_div = '0;
    logic          cfg_ready;
    logic          cfg_err;
    logic [NC-1:0] div_clk;
    logic [NC-1:0] div_tick;

    clk_div_multi #(
        .NUM_CH   (NC),
        .CNT_W    (CW),
        .INIT_DIV ({8'd1, 8'd2, 8'd3}),
        .EN_INIT  (3'b111)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .div_clk      (div_clk),
        .div_tick     (div_tick)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    // entry: [22:7] edge number, [6] cfg_err, [5:3] div_clk, [2:0] div_tick
    logic [22:0] exp_q[$];
    string       dq_name[$];
    logic [31:0] dq_act[$];
    logic [31:0] dq_exp[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    string       cur_test = "reset";

    // ---------------- reference schedule ----------------
    int   m_base[NC];
    int   m_d[NC];
    logic m_clk0[NC];
    logic m_tick0[NC];
    int   err_cyc = -1;

    function automatic logic [1:0] model_out(input int ch, input int n);
        int k;
        logic c;
        logic t;
        k = n - m_base[ch];
        if (k <= 0) return {m_clk0[ch], m_tick0[ch]};
        t = ((k % (m_d[ch] + 1)) == 0);
        c = m_clk0[ch] ^ (((k / (m_d[ch] + 1)) % 2) == 1);
        return {c, t};
    endfunction

    // Move a channel's phase origin to wrap edge w, after which divisor d rules.
    task automatic rebase(input int ch, input int w, input int d);
        logic [1:0] o;
        o = model_out(ch, w);
        m_clk0[ch]  = o[1];
        m_tick0[ch] = o[0];
        m_base[ch]  = w;
        m_d[ch]     = d;
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NC; ch++) begin
            m_base[ch]  = cyc;
            m_clk0[ch]  = 1'b0;
            m_tick0[ch] = 1'b0;
        end
        // Half-periods of 4, 3 and 2 cycles.
        m_d[0] = int'(half_period_to_div(4));
        m_d[1] = int'(half_period_to_div(3));
        m_d[2] = int'(half_period_to_div(2));
    endtask

    // ---------------- driver tasks ----------------
    // Issue the expectation for the next edge, then advance past it.
    task automatic step();
        int         n;
        logic [1:0] o;
        logic [2:0] ec;
        logic [2:0] et;
        n = cyc + 1;
        for (int ch = 0; ch < NC; ch++) begin
            if (sync_restart || !ch_en[ch]) begin
                m_base[ch]  = n;
                m_clk0[ch]  = 1'b0;
                m_tick0[ch] = 1'b0;
            end
        end
        for (int ch = 0; ch < NC; ch++) begin
            o      = model_out(ch, n);
            ec[ch] = o[1];
            et[ch] = o[0];
        end
        exp_q.push_back({16'(n), (n == err_cyc), ec, et});
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dq_name.push_back(name);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endtask

    // ---------------- monitor ----------------
    logic [22:0] mon_e;
    always @(negedge clk) begin
        while (dq_name.size() > 0) begin
            n_tests++;
            if (dq_act[0] !== dq_exp[0]) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h", dq_name[0], dq_act[0], dq_exp[0]);
            end
            void'(dq_name.pop_front());
            void'(dq_act.pop_front());
            void'(dq_exp.pop_front());
        end
        while (exp_q.size() > 0 && int'(exp_q[0][22:7]) < cyc) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL stream_missed %s: edge %0d not observed (now %0d)",
                     cur_test, int'(mon_e[22:7]), cyc);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][22:7]) == cyc) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if ({div_clk, div_tick, cfg_err} !== {mon_e[5:3], mon_e[2:0], mon_e[6]}) begin
                n_fail++;
                $display("FAIL stream %s edge %0d: got clk=%b tick=%b err=%b, expected clk=%b tick=%b err=%b",
                         cur_test, cyc, div_clk, div_tick, cfg_err, mon_e[5:3], mon_e[2:0], mon_e[6]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int r2;
        int r3;
        int w1;
        logic [1:0] o;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({div_clk, div_tick, cfg_err, cfg_ready}), 32'h01);
        #2 rst = 1'b1;
        model_reset();

        // 1: free-running schedule from reset
        cur_test = "t1_schedule";
        repeat (24) step();

        // 2: reprogram ch0 to 0 at cnt=1 after a restart
        cur_test = "t2_reprogram";
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        r = cyc;
        step();
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd0;
        #1 chk("t2_ready_idle", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        #1 chk("t2_ready_pending_a", 32'(cfg_ready), 32'd0);
        step();
        #1 chk("t2_ready_pending_b", 32'(cfg_ready), 32'd0);
        rebase(0, r + 4, 0);
        step();
        #1 chk("t2_ready_after_apply", 32'(cfg_ready), 32'd1);
        repeat (6) step();
        // ch0 wraps every edge now: an accept on a wrap waits for the next one
        cfg_valid = 1'b1; cfg_div = 8'd3;
        w1 = cyc + 1;
        step();
        cfg_valid = 1'b0;
        #1 chk("t2_ready_wrap_accept", 32'(cfg_ready), 32'd0);
        rebase(0, w1 + 1, 3);
        step();
        #1 chk("t2_ready_restored", 32'(cfg_ready), 32'd1);
        repeat (8) step();

        // 3: out-of-range write
        cur_test = "t3_oor";
        cfg_valid = 1'b1; cfg_ch = 4'd5; cfg_div = 8'd7;
        #1 chk("t3_ready_oor", 32'(cfg_ready), 32'd1);
        err_cyc = cyc + 1;
        step();
        cfg_valid = 1'b0; cfg_ch = 4'd0;
        repeat (8) step();

        // 4: restart on ch1's wrap edge
        cur_test = "t4_restart";
        while (((cyc + 1 - m_base[1]) % 3) != 0) step();
        sync_restart = 1'b1;
        r2 = cyc + 1;
        step();
        sync_restart = 1'b0;
        chk("t4_all_low", 32'({div_clk, div_tick}), 32'd0);
        repeat (8) step();

        // 4b: restart applies a pending divisor; a coincident accept stays pending
        cur_test = "t4b_restart_pending";
        step();
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd4;
        step();
        sync_restart = 1'b1; cfg_ch = 4'd2; cfg_div = 8'd2;
        #1 chk("t4b_ready_ch2", 32'(cfg_ready), 32'd1);
        m_d[1] = 4;
        r3 = cyc + 1;
        step();
        sync_restart = 1'b0; cfg_valid = 1'b0;
        #1 chk("t4b_ch2_pending", 32'(cfg_ready), 32'd0);
        cfg_ch = 4'd1;
        #1 chk("t4b_ch1_applied", 32'(cfg_ready), 32'd1);
        cfg_ch = 4'd2;
        step();
        rebase(2, r3 + 2, 2);
        step();
        #1 chk("t4b_ch2_applied", 32'(cfg_ready), 32'd1);
        repeat (12) step();

        // 5: ch2 disabled 10 cycles with a write of 5 pending
        cur_test = "t5_disable";
        ch_en = 3'b011; cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        m_d[2] = 5;
        #1 chk("t5_ready_pending", 32'(cfg_ready), 32'd0);
        step();
        #1 chk("t5_ready_applied", 32'(cfg_ready), 32'd1);
        repeat (8) step();
        ch_en = 3'b111;
        repeat (16) step();

        // 6: asynchronous reset between edges while ch0 is high
        cur_test = "t6_async_reset";
        o = model_out(0, cyc);
        while (!o[1]) begin
            step();
            o = model_out(0, cyc);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("t6_async_clear", 32'({div_clk, div_tick, cfg_err}), 32'd0);
        @(posedge clk);
        #1 chk("t6_held_in_reset", 32'({div_clk, div_tick}), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        cfg_ch = 4'd2;
        #1 chk("t6_ready_after_reset", 32'(cfg_ready), 32'd1);
        repeat (24) step();

        cur_test = "drain";
        repeat (3) @(negedge clk);
        #1 chk("queue_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised, runtime-programmable multi-channel clock divider that replaces fixed-ratio divider blocks.
- Each channel produces a registered square-wave divided clock and a one-cycle tick pulse on every toggle; ticks are the preferred clock-enable for downstream logic.
- Divisors reload through a valid/ready config port and apply glitch-free at the next wrap.
- Sits at the top level, feeding game-tick, scan/refresh and pixel-rate enables.

Parameters:
NUM_CH, 3, number of independent divider channels (1..16)
CNT_W, 25, counter and divisor width in bits
INIT_DIV, {25'd1, 25'd124999, 25'd24999999}, packed NUM_CH*CNT_W reset divisors; channel 0 occupies the LSBs
EN_INIT, 3'b111, NUM_CH-bit reset value of channel enables

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  reset; asynchronous assert, active-low (rst==0 resets)
ch_en  input  NUM_CH  per-channel run enable
sync_restart  input  1  one-cycle pulse; phase-aligns all channels
cfg_valid  input  1  divisor write request
cfg_ch  input  4  target channel index
cfg_div  input  CNT_W  new divisor value
cfg_ready  output  1  write accepted when cfg_valid && cfg_ready
cfg_err  output  1  one-cycle pulse: write to out-of-range channel dropped
div_clk  output  NUM_CH  divided square waves
div_tick  output  NUM_CH  one-cycle pulse on each div_clk toggle

Behaviour:
- Divisor semantics: active divisor D gives half-period D+1 cycles.
  - div_clk period = 2(D+1) cycles; tick every D+1 cycles.
  - D=0 gives clk/2 with tick every cycle.
- Reset (rst low, asynchronous):
  - All cnt=0, div_clk=0, div_tick=0, cfg_err=0, pending=0.
  - Active divisor = INIT_DIV slice; enable state follows ch_en input directly (EN_INIT is the documented default for the top-level tie-off).
- Running channel (ch_en[i]=1), each cycle:
  - cnt==D: cnt<=0, div_clk[i] toggles, div_tick[i]<=1. If pending[i]: D<=shadow[i], pending[i]<=0, so the new divisor governs the following half-period.
  - Otherwise: cnt<=cnt+1, div_tick[i]<=0.
  - Counter never exceeds D; compare is equality only, with no wrap past 2^CNT_W-1.
- Disabled channel (ch_en[i]=0):
  - cnt<=0, div_clk[i]<=0, div_tick[i]<=0.
  - Any pending shadow applies on the next cycle.
  - On re-enable, the first tick comes D+1 cycles later (cnt counts 0..D).
- Config handshake:
  - cfg_ready is combinational: 1 if cfg_ch>=NUM_CH, else ~pending[cfg_ch].
  - Accepted in-range write: shadow<=cfg_div, pending<=1.
  - Out-of-range write: dropped; cfg_err=1 for the next cycle.
  - An accept in the same cycle as a wrap on that channel is not applied to that wrap; it applies at the following wrap.
  - Only one outstanding write per channel; further writes stall (cfg_ready=0) until applied.
- sync_restart=1: every channel cnt<=0, div_clk<=0, div_tick<=0, and pending shadows apply immediately.
  - Overrides a coincident wrap.
  - A coincident cfg accept still lands in shadow and stays pending.
- Latency: outputs are registered; a tick asserts in the cycle after cnt==D is observed.
- Reset mid-operation: all state clears immediately, with no partial toggle.

Decomposition:
- Package clk_div_pkg: CH_IDX_W=4; default divisor constants DIV_2HZ=24999999, DIV_400HZ=124999, DIV_25MHZ=1; helper function for the half-period-to-divisor conversion.
- Sub-module clk_div_channel holds one counter, the active and shadow divisor, pending flag, div_clk and div_tick. It is instantiated NUM_CH times via generate.
- The top level keeps the config decode, cfg_ready mux and cfg_err.

Test Plan:
1. NUM_CH=3, CNT_W=8, INIT_DIV={1,2,3}; release reset -> tick0 every 4 cycles, tick1 every 3, tick2 every 2; div_clk0 period 8 cycles.
2. Write ch0 div=0 mid-count at cnt=1 -> cfg_ready(ch0)=0 until the next wrap; the following half-periods are 1 cycle; cfg_ready returns 1 the cycle after the apply.
3. Write cfg_ch=5 -> cfg_err pulses once, no divisor changes, cfg_ready=1.
4. Assert sync_restart while ch1 has cnt==2 (its wrap cycle) -> no tick on ch1; all div_clk=0; first ticks at 4/3/2 cycles after the pulse, phase-aligned.
5. ch_en[2]=0 for 10 cycles with a pending write of 5 -> div_clk2 held 0, no ticks; on re-enable the first tick comes 6 cycles later.
6. Drop rst low asynchronously mid-period (between clk edges) -> all outputs 0 immediately; after release, divisors are INIT_DIV and the schedule matches test 1.
